// File: rtl/conv3x3_pkg.sv
// Shared constants, schedule state encoding and schedule length for conv3x3_systolic.
package conv3x3_pkg;

    localparam int DATA_W = 8;
    localparam int IMG_N  = 4;
    localparam int FLT_N  = 3;
    localparam int OUT_N  = 2;

    // IDLE is never entered from reset; it parks any illegal encoding.
    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RUN,
        WRITE,
        DONE
    } state_t;

    // MAC cycles for one full run: 36 tap-window products spread over the PEs.
    function automatic int compute_len(int pe_dim);
        return (OUT_N * OUT_N * FLT_N * FLT_N) / (pe_dim * pe_dim);
    endfunction

endpackage

// File: rtl/conv_pe.sv
// One processing element: 8x8 multiplier feeding an 8-bit wrapping accumulator.
module conv_pe
    import conv3x3_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  en,
    input  logic [DATA_W-1:0]     a,
    input  logic [DATA_W-1:0]     b,
    output logic [2*DATA_W-1:0]   prod,
    output logic [DATA_W-1:0]     acc
);

    assign prod = (2*DATA_W)'(a) * (2*DATA_W)'(b);

    // clear together with en starts a fresh sum with the current product.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc <= '0;
        end else if (en) begin
            acc <= (clear ? '0 : acc) + prod[DATA_W-1:0];
        end else if (clear) begin
            acc <= '0;
        end
    end

endmodule

// File: rtl/conv3x3_systolic.sv
// 2x2 valid cross-correlation of a 4x4 image with a 3x3 filter on a PE_DIM x PE_DIM MAC array.
module conv3x3_systolic
    import conv3x3_pkg::*;
#(
    parameter int PE_DIM = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] i00, i01, i02, i03,
    input  logic [DATA_W-1:0] i10, i11, i12, i13,
    input  logic [DATA_W-1:0] i20, i21, i22, i23,
    input  logic [DATA_W-1:0] i30, i31, i32, i33,
    input  logic [DATA_W-1:0] f00, f01, f02,
    input  logic [DATA_W-1:0] f10, f11, f12,
    input  logic [DATA_W-1:0] f20, f21, f22,
    output logic [DATA_W-1:0] o00, o01, o10, o11
);

    if (!(PE_DIM inside {1, 2, 3})) begin : g_bad_dim
        $error("conv3x3_systolic: PE_DIM must be 1, 2 or 3");
    end

    localparam int         NPE  = PE_DIM * PE_DIM;
    localparam logic [5:0] LAST = 6'(compute_len(PE_DIM) - 1);

    logic [DATA_W-1:0] img_in [IMG_N][IMG_N];
    logic [DATA_W-1:0] flt_in [FLT_N][FLT_N];
    logic [DATA_W-1:0] img_q  [IMG_N][IMG_N];
    logic [DATA_W-1:0] flt_q  [FLT_N][FLT_N];

    assign img_in = '{'{i00, i01, i02, i03}, '{i10, i11, i12, i13},
                      '{i20, i21, i22, i23}, '{i30, i31, i32, i33}};
    assign flt_in = '{'{f00, f01, f02}, '{f10, f11, f12}, '{f20, f21, f22}};

    state_t     state, state_nxt;
    logic [5:0] step;
    logic       run;

    assign run = (state == RUN);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= LOAD;
        else      state <= state_nxt;
    end

    // NOTE: combinational blocks assign a default to every output first so no latch is inferred.
    always_comb begin
        state_nxt = state;
        case (state)
            LOAD:    state_nxt = RUN;
            RUN:     if (step == LAST) state_nxt = WRITE;
            WRITE:   state_nxt = DONE;
            DONE:    state_nxt = DONE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // NOTE: operand registers are cleared element by element; a reset array does not map to RAM.
            for (int r = 0; r < IMG_N; r++)
                for (int c = 0; c < IMG_N; c++) img_q[r][c] <= '0;
            for (int r = 0; r < FLT_N; r++)
                for (int c = 0; c < FLT_N; c++) flt_q[r][c] <= '0;
            step <= '0;
        end else if (state == LOAD) begin
            img_q <= img_in;
            flt_q <= flt_in;
            step  <= '0;
        end else if (run) begin
            step <= step + 6'd1;
        end
    end

    // Schedule decode: tap = filter position (row-major), win = output window o00,o01,o10,o11.
    logic [3:0] tap;
    logic [1:0] win, tap_row, tap_col;

    // NOTE: blocking assignments here are combinational temporaries; registers above use <=.
    always_comb begin
        tap = '0;
        win = '0;
        case (PE_DIM)
            1:       begin tap = 4'(step % 6'd9); win = 2'(step / 6'd9); end
            2:       tap = step[3:0];
            default: win = step[1:0];
        endcase
        tap_row = 2'(tap / 4'd3);
        tap_col = 2'(tap % 4'd3);
    end

    logic [2*DATA_W-1:0] pe_prod [FLT_N*FLT_N];
    logic [DATA_W-1:0]   pe_acc  [FLT_N*FLT_N];
    logic                pe_clear;

    assign pe_clear = (state == LOAD) || (run && tap == 4'd0);

    for (genvar k = 0; k < FLT_N*FLT_N; k++) begin : g_pe
        if (k < NPE) begin : g_on
            localparam logic [1:0] OWN_R = 2'(k / OUT_N);
            localparam logic [1:0] OWN_C = 2'(k % OUT_N);
            localparam logic [1:0] OWN_A = 2'(k / FLT_N);
            localparam logic [1:0] OWN_B = 2'(k % FLT_N);

            logic [1:0]        fr, fc, wr, wc;
            logic [DATA_W-1:0] a, b;

            // Each PE owns either a window (PE_DIM=2), a tap (PE_DIM=3) or nothing (PE_DIM=1).
            always_comb begin
                fr = tap_row;
                fc = tap_col;
                wr = {1'b0, win[1]};
                wc = {1'b0, win[0]};
                if (PE_DIM == 2) begin wr = OWN_R; wc = OWN_C; end
                if (PE_DIM == 3) begin fr = OWN_A; fc = OWN_B; end
                a = flt_q[fr][fc];
                b = img_q[wr + fr][wc + fc];
            end

            conv_pe u_pe (
                .clk   (clk),
                .rst   (rst),
                .clear (pe_clear),
                .en    (run),
                .a     (a),
                .b     (b),
                .prod  (pe_prod[k]),
                .acc   (pe_acc[k])
            );
        end else begin : g_off
            assign pe_prod[k] = '0;
            assign pe_acc[k]  = '0;
        end
    end

    logic [DATA_W-1:0] tree_sum;

    always_comb begin
        tree_sum = '0;
        for (int k = 0; k < FLT_N*FLT_N; k++) tree_sum = tree_sum + pe_prod[k][DATA_W-1:0];
    end

    // Window results: banked from the single PE (PE_DIM=1) or summed by the tree (PE_DIM=3).
    logic [DATA_W-1:0] res   [OUT_N*OUT_N];
    logic [DATA_W-1:0] fin   [OUT_N*OUT_N];
    logic [DATA_W-1:0] out_q [OUT_N*OUT_N];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < OUT_N*OUT_N; k++) res[k] <= '0;
        end else if (state == LOAD) begin
            for (int k = 0; k < OUT_N*OUT_N; k++) res[k] <= '0;
        end else if (run) begin
            if (PE_DIM == 1 && tap == 4'd0 && win != 2'd0) res[win - 2'd1] <= pe_acc[0];
            if (PE_DIM == 3) res[win] <= res[win] + tree_sum;
        end
    end

    always_comb begin
        for (int k = 0; k < OUT_N*OUT_N; k++) fin[k] = (PE_DIM == 2) ? pe_acc[k] : res[k];
        if (PE_DIM == 1) fin[3] = pe_acc[0];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < OUT_N*OUT_N; k++) out_q[k] <= '0;
        end else if (state == WRITE) begin
            out_q <= fin;
        end
    end

    assign o00 = out_q[0];
    assign o01 = out_q[1];
    assign o10 = out_q[2];
    assign o11 = out_q[3];

endmodule

// File: tb/tb_conv3x3_systolic.sv
// Directed bench: three instances (PE_DIM 1, 2, 3) share operands and are checked against hand-computed results.
module tb_conv3x3_systolic;

    typedef struct packed {
        logic [0:15][7:0] img;
        logic [0:8][7:0]  flt;
        logic [0:3][7:0]  exp;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [2:0]       rst_l;
    logic [0:15][7:0] img;
    logic [0:8][7:0]  flt;
    logic [7:0]       o [3][4];

    int tests = 0;
    int fails = 0;
    vec_t vecs [3];

    for (genvar d = 0; d < 3; d++) begin : g_dut
        conv3x3_systolic #(.PE_DIM(d + 1)) dut (
            .clk (clk), .rst (rst_l[d]),
            .i00 (img[0]),  .i01 (img[1]),  .i02 (img[2]),  .i03 (img[3]),
            .i10 (img[4]),  .i11 (img[5]),  .i12 (img[6]),  .i13 (img[7]),
            .i20 (img[8]),  .i21 (img[9]),  .i22 (img[10]), .i23 (img[11]),
            .i30 (img[12]), .i31 (img[13]), .i32 (img[14]), .i33 (img[15]),
            .f00 (flt[0]),  .f01 (flt[1]),  .f02 (flt[2]),
            .f10 (flt[3]),  .f11 (flt[4]),  .f12 (flt[5]),
            .f20 (flt[6]),  .f21 (flt[7]),  .f22 (flt[8]),
            .o00 (o[d][0]), .o01 (o[d][1]), .o10 (o[d][2]), .o11 (o[d][3])
        );
    end

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int len_of(int d);
        return 36 / ((d + 1) * (d + 1));
    endfunction

    task automatic check_all(input string tag, input int d, input logic [0:3][7:0] exp);
        for (int k = 0; k < 4; k++)
            check($sformatf("%s_pe%0d_o%0d", tag, d + 1, k), o[d][k], exp[k]);
    endtask

    // Full run: reset, release, then check zero at edge L+1, result at L+2 and at edge 40.
    task automatic run_vec(input string tag, input vec_t v, input bit zero_late);
        img   = v.img;
        flt   = v.flt;
        rst_l = 3'b000;
        @(negedge clk);
        @(negedge clk);
        for (int d = 0; d < 3; d++) check_all({tag, "_rst"}, d, '0);
        rst_l = 3'b111;
        for (int e = 1; e <= 40; e++) begin
            @(posedge clk);
            #1;
            if (zero_late && e == 1) begin
                img = '0;
                flt = '0;
            end
            for (int d = 0; d < 3; d++) begin
                if (e == len_of(d) + 1)               check_all({tag, "_pre"}, d, '0);
                if (e == len_of(d) + 2 || e == 40)    check_all({tag, "_res"}, d, v.exp);
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int rst_edge [3];
        int k;
        rst_l = 3'b000;
        img   = '0;
        flt   = '0;

        vecs[0].img = '{8'd252, 8'd165, 8'd199, 8'd27,  8'd93,  8'd28,  8'd86, 8'd176,
                        8'd149, 8'd110, 8'd113, 8'd249, 8'd234, 8'd207, 8'd29, 8'd30};
        vecs[0].flt = '{8'd181, 8'd176, 8'd207, 8'd111, 8'd248, 8'd115, 8'd64, 8'd95, 8'd253};
        vecs[0].exp = '{8'd89, 8'd86, 8'd115, 8'd106};

        vecs[1].img = '{8'd0, 8'd1, 8'd2,  8'd3,  8'd4,  8'd5,  8'd6,  8'd7,
                        8'd8, 8'd9, 8'd10, 8'd11, 8'd12, 8'd13, 8'd14, 8'd15};
        vecs[1].flt = '{8'd0, 8'd0, 8'd0, 8'd0, 8'd1, 8'd0, 8'd0, 8'd0, 8'd0};
        vecs[1].exp = '{8'd5, 8'd6, 8'd9, 8'd10};

        vecs[2].img = '{default: 8'd255};
        vecs[2].flt = '{default: 8'd255};
        vecs[2].exp = '{default: 8'd9};

        for (int i = 0; i < 3; i++) run_vec($sformatf("vec%0d", i), vecs[i], 1'b0);

        run_vec("late_change", vecs[0], 1'b1);

        for (int c = 1; c <= 100; c++) begin
            @(posedge clk);
            #1;
            if (c % 20 == 0)
                for (int d = 0; d < 3; d++) check_all($sformatf("hold%0d", c), d, vecs[0].exp);
        end

        // Mid-cycle reset with no clock edge in between must clear the outputs at once.
        #2;
        rst_l = 3'b000;
        #1;
        for (int d = 0; d < 3; d++) check_all("async_rst", d, '0);

        // Reset mid-run; operands switch to vec1 so the restart must recapture them.
        img   = vecs[0].img;
        flt   = vecs[0].flt;
        @(negedge clk);
        rst_l = 3'b111;
        rst_edge = '{20, 5, 5};
        for (int e = 1; e <= 64; e++) begin
            @(posedge clk);
            #1;
            if (e == 5) begin
                img = vecs[1].img;
                flt = vecs[1].flt;
            end
            for (int d = 0; d < 3; d++) begin
                if (e == rst_edge[d])     rst_l[d] = 1'b0;
                if (e == rst_edge[d] + 2) rst_l[d] = 1'b1;
            end
            #1;
            for (int d = 0; d < 3; d++) begin
                k = e - (rst_edge[d] + 2);
                if (e == rst_edge[d])                   check_all("mid_assert", d, '0);
                if (k == len_of(d) + 1)                 check_all("mid_pre", d, '0);
                if (k == len_of(d) + 2 || e == 64)      check_all("mid_res", d, vecs[1].exp);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/conv3x3_systolic.md
# conv3x3_systolic

Computes the 2×2 valid 2-D cross-correlation of a 4×4 8-bit image with a 3×3 8-bit filter, using a configurable square array of multiply-accumulate processing elements. It is the configurable replacement for the one-, two- and three-PE-per-side systolic variants, and sits between the operand register file and the result sink. One run executes after each reset release. Results are bit-identical for every array size; only latency differs.

## Interface
- `PE_DIM`, default 3: array side. Legal values are 1, 2 and 3, giving 1, 4 and 9 PEs. Any other value is an elaboration error.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `i00`…`i33` in 8 each: image pixel i[r][c], unsigned, 16 ports.
- `f00`…`f22` in 8 each: filter tap f[a][b], unsigned, 9 ports.
- `o00`, `o01`, `o10`, `o11` out 8 each: result o[r][c], unsigned.

## Operation
- Result: o[r][c] = (Σ_{a,b∈0..2} f[a][b]·i[r+a][c+b]) mod 256.
  - Correlation, not flipped convolution.
  - Products are 16-bit.
  - Accumulation wraps; only the low 8 bits are kept.
  - No saturation.
- Load: the first rising edge after reset release captures all 25 operands into internal registers. Operand changes after this edge are ignored until the next reset.
- Schedule for PE_DIM=1: one PE computes o00, o01, o10, o11 in that order, 9 taps each in row-major tap order. That is 36 MAC cycles.
- Schedule for PE_DIM=2: PE(r,c) owns o[r][c]. Each PE steps the 9 taps in row-major order, all four in lock-step. That is 9 MAC cycles.
- Schedule for PE_DIM=3: PE(a,b) owns tap f[a][b].
  - Each cycle, all 9 PEs multiply for one output window, in order o00, o01, o10, o11.
  - An adder tree sums the 9 products into that output's accumulator.
  - That is 4 cycles.
- Compute length: L = 36 / PE_DIM² (36, 9, 4).
- A step counter sequences the schedule. Its states are IDLE, LOAD, RUN(L cycles), WRITE and DONE.
- DONE holds until reset. The four outputs update together in WRITE and hold their values afterwards.

## Timing
- While rst=0: all outputs are 0, and all accumulators, operand registers and the counter are cleared. This takes effect immediately, without waiting for clk.
- Edge numbering is counted from the first rising edge with rst=1.
  - Edge 1: LOAD.
  - Edges 2…L+1: MACs.
  - Edge L+2: the output registers update.
- Outputs are therefore valid from edge 38 (PE_DIM=1), 11 (PE_DIM=2) or 6 (PE_DIM=3). They are 0 before that edge and stable after it.
- Reset asserted mid-run: outputs return to 0 at once and the run aborts. After release, a fresh run starts with a fresh operand capture.
- There is no handshake and no done port. Consumers count cycles using L.

## Structure
- Shared package `conv3x3_pkg` contains:
  - `DATA_W` = 8, `IMG_N` = 4, `FLT_N` = 3, `OUT_N` = 2;
  - the state enum;
  - a function `compute_len(PE_DIM)` returning L.
- Sub-module `conv_pe`: 8×8 multiplier with an 8-bit wrapping accumulator, plus clear and enable inputs.
  - Instantiated PE_DIM² times.
  - For PE_DIM=3, the PEs expose their products to the shared adder tree.

## Test plan
- Random operands, all PE_DIM values.
  - Stimulus: image rows 252,165,199,27 / 93,28,86,176 / 149,110,113,249 / 234,207,29,30; filter rows 181,176,207 / 111,248,115 / 64,95,253.
  - Required response: o00=89, o01=86, o10=115, o11=106, at edge 38/11/6 respectively. All outputs are 0 one edge earlier.
- Center-tap identity.
  - Stimulus: filter with only f11=1, image i[r][c]=4r+c.
  - Required response: o00=5, o01=6, o10=9, o11=10.
- Wrap-around.
  - Stimulus: all operands 255.
  - Required response: every output is 9 (65025 mod 256 = 1, times 9).
- Operand change after load.
  - Stimulus: the first scenario, with all inputs changed to 0 at edge 2.
  - Required response: results are still 89/86/115/106.
- Reset mid-run.
  - Stimulus: assert rst at edge 20 (PE_DIM=1) or edge 5 (PE_DIM=2, 3); hold it 2 cycles; then release.
  - Required response: outputs are 0 immediately, then the correct results appear L+2 edges after release.
- Hold.
  - Stimulus: run 100 cycles after results appear.
  - Required response: outputs are unchanged.
